alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports req0_valid/req1_valid, input, 1 each, requester i presents an operation.
REQ-004 SHALL have ports req0_ready/req1_ready, output, 1 each, operation of requester i accepted this cycle when valid and ready are both high.
REQ-005 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 32 each, operands.
REQ-006 SHALL have ports req0_op/req1_op, input, 2 each, ALU control code: 00 add, 01 sub, 10 and, 11 or.
REQ-007 SHALL have ports req0_setflags/req1_setflags, input, 1 each, update flag register on acceptance.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, response slot i holds a result.
REQ-009 SHALL have ports rsp0_ready/rsp1_ready, input, 1 each, requester i consumes the response.
REQ-010 SHALL have ports rsp0_result/rsp1_result, output, 32 each, and rsp0_flags/rsp1_flags, output, 4 each ({N,Z,C,V}).
REQ-011 SHALL have ports alu_a, alu_b, output, 32 each; alu_ctrl, output, 2; alu_result, input, 32; alu_flags, input, 4 — connection to the one shared combinational ALU.
REQ-012 SHALL have port flags_q, output, 4, architectural NZCV register.

Function
REQ-013 SHALL drive alu_a/alu_b/alu_ctrl combinationally from the granted requester; with no grant, drive requester 0 inputs.
REQ-014 SHALL consider requester i eligible when reqi_valid is high and slot i is free or drains this cycle (rspi_valid low, or rspi_valid and rspi_ready high).
REQ-015 SHALL grant at most one eligible requester per cycle; reqi_ready high only for the granted requester.
REQ-016 SHALL arbitrate round-robin: if both are eligible, grant the requester not granted at the most recent acceptance; pointer updates only on acceptance.
REQ-017 SHALL, on acceptance at edge N, capture alu_result and alu_flags into slot i and assert rspi_valid from edge N until the edge where rspi_ready is high.
REQ-018 SHALL allow slot drain and refill on the same edge; rspi_valid then stays high with new data.
REQ-019 SHALL hold rspi_result/rspi_flags stable while rspi_valid is high and rspi_ready is low.
REQ-020 SHALL make reqi_ready a pure combinational function of the valids, rsp readys, slot state and pointer; it SHALL NOT depend on operand values.
REQ-021 SHALL sustain one accepted operation per cycle when responses drain every cycle, and an alternating grant pattern when both requesters stay valid.

Reset
REQ-022 SHALL, on reset low, immediately clear rsp0_valid, rsp1_valid, flags_q and the result/flag slots to 0, and set the pointer so requester 0 wins the first tie.
REQ-023 SHALL discard an in-flight, unconsumed response on mid-operation reset; req ready outputs SHALL be 0 while reset is low.

Configuration
REQ-024 SHALL, with ALU_ARB_FLAGREG_EN defined, load flags_q from alu_flags on an accepted operation whose setflags is high, holding otherwise.
REQ-025 SHALL, without ALU_ARB_FLAGREG_EN, tie flags_q to 4'b0000 and ignore setflags; all other behaviour is unchanged.

Verification
REQ-026 SHALL cover single op: req0 add a=5 b=3, rsp0_ready=1 -> req0_ready same cycle; next cycle rsp0_valid=1, result 8, flags 0000.
REQ-027 SHALL cover tie: both valid every cycle after reset, responses always ready -> grants 0,1,0,1; req1 sub 0-1 yields result FFFFFFFF, flags 1000.
REQ-028 SHALL cover backpressure: rsp0_ready=0 with slot 0 full and req0 valid -> req0_ready=0, rsp0 holds value; req1 still granted every cycle.
REQ-029 SHALL cover flags (macro on): req1 sub a=7 b=7 setflags=1 -> flags_q=0110; then and op setflags=0 -> flags_q stays 0110; macro off -> flags_q stays 0000.
REQ-030 SHALL cover same-edge drain/refill: slot 0 full, rsp0_ready=1, req0 or a=F0 b=0F -> accepted; rsp0_valid stays high, result 000000FF.
REQ-031 SHALL cover mid-operation reset: pulse reset low with both slots full -> rsp valids 0 immediately, flags_q 0, first tie afterwards granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external combinational ALU
// between two requesters. Each requester has a one-entry response slot. A
// requester is granted only when its slot is free or is draining this cycle.
// Optional flag register: define ALU_ARB_FLAGREG_EN to enable flags_q.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  input  logic        req0_setflags,
  input  logic        req1_setflags,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp0_flags,
  output logic [3:0]  rsp1_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags_q
);

  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_result_q, rsp0_result_d;
  logic [31:0] rsp1_result_q, rsp1_result_d;
  logic [3:0]  rsp0_flags_q, rsp0_flags_d;
  logic [3:0]  rsp1_flags_q, rsp1_flags_d;
  // prio_q = 0: requester 0 wins a tie; 1: requester 1 wins a tie
  logic        prio_q, prio_d;
  logic        elig0, elig1, grant0, grant1;

  // Eligibility and grant depend only on valids, slot state, rsp readys and
  // the pointer, never on operands.
  always_comb begin
    elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
    grant0 = elig0 & (~elig1 | ~prio_q);
    grant1 = elig1 & (~elig0 | prio_q);
    // Ready is forced low while reset is asserted
    req0_ready = grant0 & reset;
    req1_ready = grant1 & reset;
  end

  // Steer the shared ALU; requester 0 drives it when nobody is granted
  always_comb begin
    if (grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_op;
    end else begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_op;
    end
  end

  // Slot update: a grant refills (possibly on the same edge as a drain),
  // otherwise a consumed response empties the slot; data only moves on grant.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_flags_d  = rsp0_flags_q;
    rsp1_flags_d  = rsp1_flags_q;
    prio_d        = prio_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      rsp0_flags_d  = alu_flags;
      prio_d        = 1'b1;
    end else if (rsp0_ready) begin
      rsp0_valid_d  = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      rsp1_flags_d  = alu_flags;
      prio_d        = 1'b0;
    end else if (rsp1_ready) begin
      rsp1_valid_d  = 1'b0;
    end
  end

  // Slot and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_flags_q  <= '0;
      rsp1_flags_q  <= '0;
      prio_q        <= 1'b0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_flags_q  <= rsp1_flags_d;
      prio_q        <= prio_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_flags  = rsp0_flags_q;
  assign rsp1_flags  = rsp1_flags_q;

`ifdef ALU_ARB_FLAGREG_EN
  logic [3:0] flag_reg_q, flag_reg_d;

  // Architectural NZCV loads from the ALU on a granted setflags operation
  always_comb begin
    flag_reg_d = flag_reg_q;
    if ((grant0 & req0_setflags) | (grant1 & req1_setflags))
      flag_reg_d = alu_flags;
  end

  // Flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flag_reg_q <= '0;
    else        flag_reg_q <= flag_reg_d;
  end

  assign flags_q = flag_reg_q;
`else
  // Without the flag register setflags has no effect
  logic unused_setflags;
  assign unused_setflags = req0_setflags ^ req1_setflags;
  assign flags_q = 4'b0000;
`endif

endmodule
